// File: rtl/call_latch_if.sv
// Call-button bundle between the button panel side and the call latch.
// The latch owns the pending-call registers; the panel side drives buttons, clears and floor.
interface call_latch_if #(
   parameter int BUTTONS_WIDTH = 8,
   parameter int LEVEL_WIDTH   = 3
);
   logic [BUTTONS_WIDTH-1:0] btn_in;
   logic [BUTTONS_WIDTH-1:0] btn_up_out;
   logic [BUTTONS_WIDTH-1:0] btn_down_out;
   logic [BUTTONS_WIDTH-1:0] inactivate_in_levels;
   logic [BUTTONS_WIDTH-1:0] inactivate_out_up_levels;
   logic [BUTTONS_WIDTH-1:0] inactivate_out_down_levels;
   logic [LEVEL_WIDTH-1:0]   current_level;
   logic [BUTTONS_WIDTH-1:0] active_in_levels;
   logic [BUTTONS_WIDTH-1:0] active_out_up_levels;
   logic [BUTTONS_WIDTH-1:0] active_out_down_levels;
   logic                     any_request;
   logic                     req_above;
   logic                     req_here;
   logic                     req_below;

   modport master (
      output btn_in, btn_up_out, btn_down_out,
      output inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
      output current_level,
      input  active_in_levels, active_out_up_levels, active_out_down_levels,
      input  any_request, req_above, req_here, req_below
   );

   modport slave (
      input  btn_in, btn_up_out, btn_down_out,
      input  inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
      input  current_level,
      output active_in_levels, active_out_up_levels, active_out_down_levels,
      output any_request, req_above, req_here, req_below
   );
endinterface

// File: rtl/call_latch.sv
// Synchronises, debounces and edge-detects elevator call buttons, latches them as pending
// calls until cleared, and summarises pending calls relative to the current floor.
module call_latch #(
   parameter int BUTTONS_WIDTH   = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LEVEL_WIDTH     = 3
) (
   input logic         clk,
   input logic         reset,
   call_latch_if.slave bus
);
   localparam int NUM_LINES = 3 * BUTTONS_WIDTH;
   localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("call_latch: SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("call_latch: DEBOUNCE_CYCLES must be at least 1");
   end
   if (LEVEL_WIDTH < $clog2(BUTTONS_WIDTH)) begin : g_bad_level
      $error("call_latch: LEVEL_WIDTH too narrow for BUTTONS_WIDTH");
   end

   logic [NUM_LINES-1:0] w_exist;
   logic [NUM_LINES-1:0] w_raw;
   logic [NUM_LINES-1:0] w_sync;
   logic [NUM_LINES-1:0] w_at_last;
   logic [NUM_LINES-1:0] w_press;
   logic [NUM_LINES-1:0] w_clear;
   logic [BUTTONS_WIDTH-1:0] w_any_vec;
   logic                 w_req_above;
   logic                 w_req_here;
   logic                 w_req_below;

   logic [NUM_LINES-1:0] r_sync [SYNC_STAGES];
   logic [NUM_LINES-1:0] r_deb;
   logic [CNT_WIDTH-1:0] r_cnt [NUM_LINES];
   logic [NUM_LINES-1:0] r_active;

   // Line order is car calls, then hall-up, then hall-down; the top-floor up button and
   // the ground-floor down button do not exist and are masked off for good.
   always_comb begin
      w_exist                    = '1;
      w_exist[2*BUTTONS_WIDTH-1] = 1'b0;
      w_exist[2*BUTTONS_WIDTH]   = 1'b0;
   end

   assign w_raw   = {bus.btn_down_out, bus.btn_up_out, bus.btn_in} & w_exist;
   assign w_clear = {bus.inactivate_out_down_levels, bus.inactivate_out_up_levels,
                     bus.inactivate_in_levels};
   assign w_sync  = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            r_sync[k] <= '0;
         end
      end else begin
         r_sync[0] <= w_raw;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
         end
      end
   end

   // A line is accepted once it has disagreed with its debounced level for
   // DEBOUNCE_CYCLES consecutive synchronised samples.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_deb <= '0;
         for (int i = 0; i < NUM_LINES; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_LINES; i++) begin
            if (w_sync[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_deb[i] <= w_sync[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   always_comb begin
      w_at_last = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         w_at_last[i] = (r_cnt[i] == CNT_LAST);
      end
   end

   // The press is the very edge on which the debounced level rises, so it latches
   // together with the debounced state rather than a cycle later.
   assign w_press = w_sync & ~r_deb & w_at_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_active <= '0;
      end else begin
         r_active <= (r_active | w_press) & ~w_clear & w_exist;
      end
   end

   assign w_any_vec = r_active[BUTTONS_WIDTH-1:0]
                    | r_active[2*BUTTONS_WIDTH-1:BUTTONS_WIDTH]
                    | r_active[3*BUTTONS_WIDTH-1:2*BUTTONS_WIDTH];

   // A floor index beyond the building lands every pending call in the below bucket.
   always_comb begin
      w_req_above = 1'b0;
      w_req_here  = 1'b0;
      w_req_below = 1'b0;
      for (int f = 0; f < BUTTONS_WIDTH; f++) begin
         if (f > int'(bus.current_level)) begin
            w_req_above = w_req_above | w_any_vec[f];
         end else if (f == int'(bus.current_level)) begin
            w_req_here = w_req_here | w_any_vec[f];
         end else begin
            w_req_below = w_req_below | w_any_vec[f];
         end
      end
   end

   assign bus.active_in_levels       = r_active[BUTTONS_WIDTH-1:0];
   assign bus.active_out_up_levels   = r_active[2*BUTTONS_WIDTH-1:BUTTONS_WIDTH];
   assign bus.active_out_down_levels = r_active[3*BUTTONS_WIDTH-1:2*BUTTONS_WIDTH];
   assign bus.any_request            = |w_any_vec;
   assign bus.req_above              = w_req_above;
   assign bus.req_here               = w_req_here;
   assign bus.req_below              = w_req_below;
endmodule

// File: tb/tb_call_latch.sv
// Bench for call_latch: directed scenarios followed by random button traffic, all checked
// every cycle against a sample-window model of the button conditioning.
module tb_call_latch;
   localparam int BW   = 8;
   localparam int SYNC = 2;
   localparam int DC   = 4;
   localparam int LW   = 3;
   localparam int N    = 3 * BW;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   call_latch_if #(.BUTTONS_WIDTH(BW), .LEVEL_WIDTH(LW)) bus ();

   call_latch #(
      .BUTTONS_WIDTH(BW), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .LEVEL_WIDTH(LW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] exist;
   logic [N-1:0] mDeb;
   logic [N-1:0] mActive;
   logic [N-1:0] rawHist[$];

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelClear();
      mDeb    = '0;
      mActive = '0;
      rawHist.delete();
   endtask

   // A line flips its debounced level when the last DC synchronised samples (the raw
   // samples SYNC..SYNC+DC-1 edges back) all disagree with it.
   task automatic modelStep();
      logic [N-1:0] raw, press, clr, h;
      logic allDiff, sv;
      int idx;
      raw = {bus.btn_down_out, bus.btn_up_out, bus.btn_in} & exist;
      clr = {bus.inactivate_out_down_levels, bus.inactivate_out_up_levels,
             bus.inactivate_in_levels};
      rawHist.push_front(raw);
      if (rawHist.size() > SYNC + DC) void'(rawHist.pop_back());
      press = '0;
      for (int i = 0; i < N; i++) begin
         allDiff = 1'b1;
         for (int m = 0; m < DC; m++) begin
            idx = SYNC + m;
            if (idx < rawHist.size()) begin
               h  = rawHist[idx];
               sv = h[i];
            end else begin
               sv = 1'b0;
            end
            if (sv == mDeb[i]) allDiff = 1'b0;
         end
         if (allDiff) begin
            mDeb[i] = ~mDeb[i];
            if (mDeb[i]) press[i] = 1'b1;
         end
      end
      mActive = (mActive | press) & ~clr & exist;
   endtask

   task automatic checkAll();
      logic [BW-1:0] aIn, aUp, aDn, anyVec;
      logic eAbove, eHere, eBelow;
      int lvl;
      aIn    = mActive[BW-1:0];
      aUp    = mActive[2*BW-1:BW];
      aDn    = mActive[3*BW-1:2*BW];
      anyVec = aIn | aUp | aDn;
      lvl    = int'(bus.current_level);
      eAbove = 1'b0;
      eHere  = 1'b0;
      eBelow = 1'b0;
      for (int f = 0; f < BW; f++) begin
         if (anyVec[f]) begin
            if (f > lvl) eAbove = 1'b1;
            if (f == lvl) eHere = 1'b1;
            if (f < lvl) eBelow = 1'b1;
         end
      end
      checkOutput("active_in",   32'(bus.active_in_levels),       32'(aIn));
      checkOutput("active_up",   32'(bus.active_out_up_levels),   32'(aUp));
      checkOutput("active_down", 32'(bus.active_out_down_levels), 32'(aDn));
      checkOutput("any_request", 32'(bus.any_request),            32'(anyVec != '0));
      checkOutput("req_above",   32'(bus.req_above),              32'(eAbove));
      checkOutput("req_here",    32'(bus.req_here),               32'(eHere));
      checkOutput("req_below",   32'(bus.req_below),              32'(eBelow));
   endtask

   // One clock: the model takes the edge with the same inputs the DUT sees, and the
   // outputs are compared on the following falling edge.
   task automatic applyStimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         if (reset) modelStep();
         else modelClear();
         @(negedge clk);
         checkAll();
      end
   endtask

   task automatic doReset(input int cycles);
      reset = 1'b0;
      modelClear();
      #1;
      checkAll();
      applyStimulus(cycles);
      reset = 1'b1;
   endtask

   task automatic clearAll();
      bus.inactivate_in_levels       = '1;
      bus.inactivate_out_up_levels   = '1;
      bus.inactivate_out_down_levels = '1;
      applyStimulus(1);
      bus.inactivate_in_levels       = '0;
      bus.inactivate_out_up_levels   = '0;
      bus.inactivate_out_down_levels = '0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      exist  = '1;
      exist[2*BW-1] = 1'b0;
      exist[2*BW]   = 1'b0;
      reset = 1'b0;
      bus.btn_in = '0;
      bus.btn_up_out = '0;
      bus.btn_down_out = '0;
      bus.inactivate_in_levels = '0;
      bus.inactivate_out_up_levels = '0;
      bus.inactivate_out_down_levels = '0;
      bus.current_level = '0;
      modelClear();

      @(negedge clk);
      doReset(3);
      checkOutput("reset_any", 32'(bus.any_request), 32'(0));

      // Car call at floor 3 seen from floor 1.
      bus.btn_in = 8'h08;
      bus.current_level = 3'd1;
      applyStimulus(5);
      checkOutput("t1_edge5", 32'(bus.active_in_levels), 32'h00);
      applyStimulus(1);
      checkOutput("t1_edge6", 32'(bus.active_in_levels), 32'h08);
      checkOutput("t1_above", 32'(bus.req_above), 32'(1));
      checkOutput("t1_here",  32'(bus.req_here),  32'(0));
      checkOutput("t1_below", 32'(bus.req_below), 32'(0));
      applyStimulus(4);
      bus.btn_in = '0;
      applyStimulus(6);
      clearAll();

      // Short glitch on hall-up 2, then a proper press.
      bus.btn_up_out = 8'h04;
      applyStimulus(2);
      bus.btn_up_out = 8'h00;
      applyStimulus(3);
      checkOutput("t2_glitch", 32'(bus.active_out_up_levels), 32'h00);
      bus.btn_up_out = 8'h04;
      applyStimulus(5);
      checkOutput("t2_edge5", 32'(bus.active_out_up_levels), 32'h00);
      bus.btn_up_out = 8'h00;
      applyStimulus(1);
      checkOutput("t2_edge6", 32'(bus.active_out_up_levels), 32'h04);
      applyStimulus(6);
      clearAll();

      // Clear while held does not re-latch; release and press again does.
      bus.btn_down_out = 8'h20;
      applyStimulus(8);
      checkOutput("t3_latched", 32'(bus.active_out_down_levels), 32'h20);
      bus.inactivate_out_down_levels = 8'h20;
      applyStimulus(1);
      bus.inactivate_out_down_levels = 8'h00;
      checkOutput("t3_cleared", 32'(bus.active_out_down_levels), 32'h00);
      applyStimulus(6);
      checkOutput("t3_held", 32'(bus.active_out_down_levels), 32'h00);
      bus.btn_down_out = 8'h00;
      applyStimulus(6);
      bus.btn_down_out = 8'h20;
      applyStimulus(7);
      checkOutput("t3_relatch", 32'(bus.active_out_down_levels), 32'h20);
      bus.btn_down_out = 8'h00;
      applyStimulus(6);
      clearAll();

      // Clear coinciding with the press edge wins.
      bus.btn_in = 8'h10;
      applyStimulus(5);
      bus.inactivate_in_levels = 8'h10;
      applyStimulus(1);
      bus.inactivate_in_levels = 8'h00;
      checkOutput("t4_clear_wins", 32'(bus.active_in_levels), 32'h00);
      applyStimulus(4);
      checkOutput("t4_no_relatch", 32'(bus.active_in_levels), 32'h00);
      bus.btn_in = 8'h00;
      applyStimulus(6);

      // Buttons that do not exist never latch.
      bus.btn_up_out = 8'h80;
      bus.btn_down_out = 8'h01;
      applyStimulus(10);
      checkOutput("t5_any", 32'(bus.any_request), 32'(0));
      bus.btn_up_out = 8'h00;
      bus.btn_down_out = 8'h00;
      applyStimulus(6);

      // Reset in the middle of a held button re-runs the full latency.
      bus.btn_in = 8'h01;
      bus.current_level = 3'd0;
      applyStimulus(3);
      doReset(3);
      checkOutput("t6_in_reset", 32'(bus.active_in_levels), 32'h00);
      applyStimulus(5);
      checkOutput("t6_edge5", 32'(bus.active_in_levels), 32'h00);
      applyStimulus(1);
      checkOutput("t6_edge6", 32'(bus.active_in_levels), 32'h01);
      checkOutput("t6_here",  32'(bus.req_here), 32'(1));
      bus.btn_in = 8'h00;
      applyStimulus(6);

      // Random traffic: each line toggles with probability 1/8, clears with 1/16.
      for (int c = 0; c < 800; c++) begin
         bus.btn_in       = bus.btn_in       ^ BW'($urandom & $urandom & $urandom);
         bus.btn_up_out   = bus.btn_up_out   ^ BW'($urandom & $urandom & $urandom);
         bus.btn_down_out = bus.btn_down_out ^ BW'($urandom & $urandom & $urandom);
         bus.inactivate_in_levels       = BW'($urandom & $urandom & $urandom & $urandom);
         bus.inactivate_out_up_levels   = BW'($urandom & $urandom & $urandom & $urandom);
         bus.inactivate_out_down_levels = BW'($urandom & $urandom & $urandom & $urandom);
         if ($urandom_range(0, 9) == 0) bus.current_level = LW'($urandom_range(0, BW - 1));
         if (c == 400) begin
            doReset(2);
         end
         applyStimulus(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
